mem_access_unit: RTL and testbench

- Initiator-side load/store unit. Turns byte-addressed core memory operations (LB/LBU/LH/LHU/LW/SB/SH/SW) into accesses on the team's word-indexed data memory port.
- That port has a combinational read, a synchronous write, and whole-word writes only.
- Sub-word stores are done as a read-modify-write sequence.
- Sits between the datapath's memory stage and the data memory. It provides a valid/ready request handshake and a single-cycle response pulse.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 69 ++++++
 tb/tb_mem_access_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response and data-memory signals of the load/store unit.
// Modport slave is the unit itself. Modport master is the core plus the memory model, which drive req_* and mem_rd.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store unit in front of a word-indexed memory, with read-modify-write for SB/SH.
// Ports: clk, rst (async, active-low). bus (slave) carries the req valid/ready handshake, the one-cycle resp pulse,
// and the memory port mem_a/mem_we/mem_wd/mem_rd (combinational read, synchronous whole-word write).
module mem_access_unit #(
  parameter int MEM_WORDS = 100,
  parameter int ADDR_W    = 32
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  localparam logic [3:0] OP_SW = 4'b1010;
  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_q, data_d;
  logic              err_q, err_d, accept, sub_store;
  logic [4:0]        sh;
  logic [31:0]       rd_sh, mask, merged, ld;
  assign accept    = state_q == IDLE && bus.req_valid;
  // The legal codes put the size in op[1:0]: op[0] marks a half, op[1] marks a word.
  assign err_d     = !(bus.req_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010})
                   || (bus.req_op[0] && bus.req_addr[0])
                   || (bus.req_op[1] && |bus.req_addr[1:0])
                   || ((bus.req_addr >> 2) >= ADDR_W'(MEM_WORDS));
  assign sub_store = op_q[3] && !op_q[1];
  assign sh        = {addr_q[1:0], 3'b000};
  assign rd_sh     = bus.mem_rd >> sh;
  assign mask      = (op_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
  assign merged    = (bus.mem_rd & ~mask) | ((wdata_q << sh) & mask);
  // op[2] selects the unsigned variants, so it suppresses sign extension.
  assign ld        = op_q[1] ? rd_sh
                   : op_q[0] ? {{16{~op_q[2] & rd_sh[15]}}, rd_sh[15:0]}
                   : {{24{~op_q[2] & rd_sh[7]}}, rd_sh[7:0]};
  always_comb begin
    state_d = state_q == IDLE   ? (bus.req_valid ? ACCESS : IDLE)
            : state_q == ACCESS ? ((!err_q && sub_store) ? WRITE : RESP)
            : state_q == WRITE  ? RESP : IDLE;
    data_d  = state_q == ACCESS ? (err_q ? 32'h0 : op_q[3] ? merged : ld) : data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= err_d;
      end
    end
  end
  // Outputs decode straight from state_q, so an asynchronous reset drops mem_we immediately.
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err   = state_q == RESP && err_q;
  assign bus.resp_rdata = (state_q == RESP && !op_q[3]) ? data_q : 32'h0;
  assign bus.mem_a      = state_q == IDLE ? '0 : addr_q >> 2;
  assign bus.mem_we     = (state_q == ACCESS && op_q == OP_SW && !err_q) || state_q == WRITE;
  assign bus.mem_wd     = state_q == WRITE ? data_q : bus.mem_we ? wdata_q : 32'h0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the load/store unit against a behavioural word memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_mem = 1'b1;
  logic [31:0] mem [100];
  int passed = 0;
  int total = 0;
  mem_access_unit_if #(.ADDR_W(32)) bus();
  mem_access_unit #(.MEM_WORDS(100), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rd = bus.mem_a < 100 ? mem[bus.mem_a[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 100; i++) mem[i] <= (i == 5) ? 32'h8899_AABB : 32'h0;
    end else if (bus.mem_we && bus.mem_a < 100) begin
      mem[bus.mem_a[6:0]] <= bus.mem_wd;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic wait_resp(output int lat, output int we_cnt, output int we_n, output logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output logic [31:0] a1);
    lat = 0; we_cnt = 0; we_n = 0; wd = 0; rd = 0; er = 0; a1 = 0;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) a1 = bus.mem_a;
      if (bus.mem_we) begin
        we_cnt++;
        we_n = n;
        wd = bus.mem_wd;
      end
      if (bus.resp_valid) begin
        lat = n;
        rd = bus.resp_rdata;
        er = bus.resp_err;
      end
    end
  endtask
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input int exp_we,
                     input logic [31:0] exp_wd);
    int lat, we_cnt, we_n;
    logic [31:0] wd, rd, a1;
    logic er;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_op = op;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_resp(lat, we_cnt, we_n, wd, rd, er, a1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_we_cnt"}, we_cnt, exp_we);
    if (addr < 32'h190) chk({tag, "_mem_a"}, a1, addr >> 2);
    if (exp_we != 0) begin
      chk({tag, "_we_cycle"}, we_n, exp_lat - 1);
      chk({tag, "_wd"}, wd, exp_wd);
    end
  endtask
  initial begin
    int lat, we_cnt, we_n, bad;
    logic [31:0] wd, rd, a1;
    logic er;
    bus.req_valid = 1'b0;
    bus.req_op = 4'h0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    rst = 1'b1;
    load_mem = 1'b0;
    run("lw",   4'b0010, 32'h14, 32'h0, 32'h8899_AABB, 1'b0, 2, 0, 32'h0);
    run("lb3",  4'b0000, 32'h17, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 0, 32'h0);
    run("lbu3", 4'b0100, 32'h17, 32'h0, 32'h0000_0088, 1'b0, 2, 0, 32'h0);
    run("lb0",  4'b0000, 32'h14, 32'h0, 32'hFFFF_FFBB, 1'b0, 2, 0, 32'h0);
    run("lh2",  4'b0001, 32'h16, 32'h0, 32'hFFFF_8899, 1'b0, 2, 0, 32'h0);
    run("lhu0", 4'b0101, 32'h14, 32'h0, 32'h0000_AABB, 1'b0, 2, 0, 32'h0);
    run("sb",   4'b1000, 32'h15, 32'h1234_5677, 32'h0, 1'b0, 3, 1, 32'h8899_77BB);
    run("lw_sb", 4'b0010, 32'h14, 32'h0, 32'h8899_77BB, 1'b0, 2, 0, 32'h0);
    run("sh",   4'b1001, 32'h16, 32'h0000_CAFE, 32'h0, 1'b0, 3, 1, 32'hCAFE_77BB);
    run("lw_sh", 4'b0010, 32'h14, 32'h0, 32'hCAFE_77BB, 1'b0, 2, 0, 32'h0);
    run("e_sh_mis", 4'b1001, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 0, 32'h0);
    run("e_lw_mis", 4'b0010, 32'h16, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0);
    run("e_op3",    4'b0011, 32'h14, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0);
    run("e_range",  4'b0010, 32'h190, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0);
    chk("err_mem5", mem[5], 32'hCAFE_77BB);
    @(negedge clk);
    bus.req_op = 4'b1000;
    bus.req_addr = 32'h15;
    bus.req_wdata = 32'h0000_00AA;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_mem_a", bus.mem_a, 32'd5);
    rst = 1'b0;
    #1;
    chk("mid_we_in_rst", {31'b0, bus.mem_we}, 32'd0);
    chk("mid_ready_in_rst", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_we || !bus.req_ready) bad++;
    end
    chk("mid_no_activity", bad, 0);
    chk("mid_mem5", mem[5], 32'hCAFE_77BB);
    run("lw_after_rst", 4'b0010, 32'h14, 32'h0, 32'hCAFE_77BB, 1'b0, 2, 0, 32'h0);
    @(negedge clk);
    bus.req_op = 4'b1010;
    bus.req_addr = 32'h8;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    @(posedge clk);
    wait_resp(lat, we_cnt, we_n, wd, rd, er, a1);
    chk("b2b_sw_lat", lat, 2);
    chk("b2b_sw_we", we_cnt, 1);
    chk("b2b_sw_wd", wd, 32'hDEAD_BEEF);
    chk("b2b_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
    bus.req_op = 4'b0010;
    @(negedge clk);
    chk("b2b_ready_after", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_resp(lat, we_cnt, we_n, wd, rd, er, a1);
    chk("b2b_lw_lat", lat, 2);
    chk("b2b_lw_rdata", rd, 32'hDEAD_BEEF);
    chk("b2b_lw_we", we_cnt, 0);
    chk("b2b_mem2", mem[2], 32'hDEAD_BEEF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
